// File: rtl/dm_io_responder.sv
// dm_io_responder
// Data-side responder for a single-cycle CPU load/store bus. Each access is
// decoded into a word-organised RAM region (byte/half/word lanes) or a
// memory-mapped I/O window with an LED register, a synchronized switch
// input and a compare-match timer that can raise an interrupt.
//
// Ports:
//   clk      in   1   clock; every state update happens on the rising edge
//   reset    in   1   synchronous active-high reset
//   DMWr     in   1   store strobe
//   addr     in  32   byte address
//   din      in  32   store data (value sits in the low bits)
//   DMType   in   3   000 w, 001 h, 010 hu, 011 b, 100 bu, others illegal
//   dout     out 32   combinational load data
//   sw_in    in  16   board switches (asynchronous to clk)
//   led_out  out 16   LED register
//   irq      out  1   timer interrupt
//   bus_err  out  1   sticky flag, set by an erroneous store
module dm_io_responder #(
  parameter int          RAM_WORDS = 128,
  parameter logic [31:0] IO_BASE   = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DMWr,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  DMType,
  output logic [31:0] dout,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        irq,
  output logic        bus_err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  // ---------------- access decode ----------------
  logic        w_is_word, w_is_half, w_is_byte, w_signed, w_type_ok, w_aligned;
  logic        w_in_ram, w_in_io, w_io_mapped, w_err;
  logic [7:0]  w_io_off;
  logic [AW-1:0] w_word_idx;

  assign w_is_word  = (DMType == 3'd0);
  assign w_is_half  = (DMType == 3'd1) || (DMType == 3'd2);
  assign w_is_byte  = (DMType == 3'd3) || (DMType == 3'd4);
  assign w_signed   = (DMType == 3'd1) || (DMType == 3'd3);
  assign w_type_ok  = w_is_word || w_is_half || w_is_byte;
  assign w_aligned  = w_is_byte || (w_is_half && !addr[0]) || (w_is_word && (addr[1:0] == 2'b00));

  assign w_in_ram   = (addr < RAM_BYTES);
  // RAM takes precedence should a parameter choice ever make the regions overlap.
  assign w_in_io    = !w_in_ram && (addr[31:8] == IO_BASE[31:8]);
  assign w_io_off   = addr[7:0];
  assign w_io_mapped = (w_io_off == 8'h00) || (w_io_off == 8'h04) || (w_io_off == 8'h08) ||
                       (w_io_off == 8'h0C) || (w_io_off == 8'h10) || (w_io_off == 8'h14);
  assign w_word_idx = addr[AW+1:2];

  // The SW register is read-only, so only a store there counts as an error.
  assign w_err = !w_type_ok || !w_aligned || !(w_in_ram || w_in_io) ||
                 (w_in_io && (!w_is_word || !w_io_mapped)) ||
                 (w_in_io && DMWr && (w_io_off == 8'h04));

  logic w_st_ok, w_ram_we, w_io_we;
  logic w_wr_led, w_wr_count, w_wr_cmp, w_wr_ctrl, w_wr_status;

  assign w_st_ok     = DMWr && !w_err;
  assign w_ram_we    = w_st_ok && w_in_ram && !reset;
  assign w_io_we     = w_st_ok && w_in_io;
  assign w_wr_led    = w_io_we && (w_io_off == 8'h00);
  assign w_wr_count  = w_io_we && (w_io_off == 8'h08);
  assign w_wr_cmp    = w_io_we && (w_io_off == 8'h0C);
  assign w_wr_ctrl   = w_io_we && (w_io_off == 8'h10);
  assign w_wr_status = w_io_we && (w_io_off == 8'h14);

  // ---------------- RAM, one array per byte lane ----------------
  logic [3:0]  w_lane_we;
  logic [31:0] w_wdata, w_ram_rdata;

  always_comb begin
    w_lane_we = 4'b0000;
    w_wdata   = din;
    if (w_is_half) begin
      w_wdata   = {din[15:0], din[15:0]};
      w_lane_we = addr[1] ? 4'b1100 : 4'b0011;
    end else if (w_is_byte) begin
      w_wdata   = {4{din[7:0]}};
      w_lane_we = 4'b0001 << addr[1:0];
    end else begin
      w_lane_we = 4'b1111;
    end
    if (!w_ram_we) w_lane_we = 4'b0000;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [RAM_WORDS];
      always_ff @(posedge clk) begin
        if (w_lane_we[gi]) r_mem[w_word_idx] <= w_wdata[8*gi +: 8];
      end
      assign w_ram_rdata[8*gi +: 8] = r_mem[w_word_idx];
    end
  endgenerate

  // ---------------- I/O and timer state ----------------
  logic [15:0] r_led, r_sw_meta, r_sw_sync;
  logic [31:0] r_count, r_cmp;
  logic [2:0]  r_ctrl;        // {irq_en, auto_reload, en}
  logic        r_match, r_bus_err;
  logic        w_match_set;
  logic [31:0] w_count_next;

  // Match uses the pre-edge COUNT/CMP; a CPU store to COUNT beats the timer.
  assign w_match_set = r_ctrl[0] && (r_count == r_cmp);

  always_comb begin
    w_count_next = r_count;
    if (w_wr_count)       w_count_next = din;
    else if (w_match_set) w_count_next = r_ctrl[1] ? 32'd0 : r_count + 32'd1;
    else if (r_ctrl[0])   w_count_next = r_count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_count   <= '0;
      r_cmp     <= 32'hFFFF_FFFF;
      r_ctrl    <= '0;
      r_match   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      r_count   <= w_count_next;
      if (w_wr_led)  r_led  <= din[15:0];
      if (w_wr_cmp)  r_cmp  <= din;
      if (w_wr_ctrl) r_ctrl <= din[2:0];
      // A new match wins over a write-1-to-clear in the same cycle.
      r_match   <= w_match_set || (r_match && !(w_wr_status && din[0]));
      if (DMWr && w_err) r_bus_err <= 1'b1;
    end
  end

  // ---------------- load path ----------------
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = addr[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
  assign w_byte = w_ram_rdata[8*addr[1:0] +: 8];

  always_comb begin
    dout = 32'h0;
    if (!w_err) begin
      if (w_in_ram) begin
        if (w_is_word)      dout = w_ram_rdata;
        else if (w_is_half) dout = w_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        else                dout = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end else begin
        case (w_io_off)
          8'h00:   dout = {16'h0, r_led};
          8'h04:   dout = {16'h0, r_sw_sync};
          8'h08:   dout = r_count;
          8'h0C:   dout = r_cmp;
          8'h10:   dout = {29'h0, r_ctrl};
          8'h14:   dout = {31'h0, r_match};
          default: dout = 32'h0;
        endcase
      end
    end
  end

  assign led_out = r_led;
  assign irq     = r_match && r_ctrl[2];
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_dm_io_responder.sv
// Directed testbench for dm_io_responder: RAM lanes, error handling,
// switch synchronizer, LED register, timer with auto-reload/irq and reset.
module tb_dm_io_responder;

  logic        clk = 1'b0;
  logic        reset, DMWr;
  logic [31:0] addr, din, dout;
  logic [2:0]  DMType;
  logic [15:0] sw_in, led_out;
  logic        irq, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] IOB = 32'h0000_FF00;
  localparam logic [2:0] T_W = 3'd0, T_H = 3'd1, T_HU = 3'd2, T_B = 3'd3, T_BU = 3'd4;

  dm_io_responder #(.RAM_WORDS(128), .IO_BASE(IOB)) dut (
    .clk(clk), .reset(reset), .DMWr(DMWr), .addr(addr), .din(din),
    .DMType(DMType), .dout(dout), .sw_in(sw_in), .led_out(led_out),
    .irq(irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    DMWr = 1'b1; addr = a; din = d; DMType = t;
    @(posedge clk); #1;
    DMWr = 1'b0;
    $display("store addr=%08h data=%08h type=%0d", a, d, t);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
    DMWr = 1'b0; addr = a; DMType = t;
    #1;
    d = dout;
    $display("load  addr=%08h type=%0d -> %08h", a, t, d);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset pulse");
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_cnt [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

  initial begin
    reset = 1'b1; DMWr = 1'b0; addr = '0; din = '0; DMType = T_W; sw_in = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ---- reset state ----
    chk_val("rst_led", {16'h0, led_out}, 32'h0);
    chk_val("rst_buserr", {31'h0, bus_err}, 32'h0);
    chk_val("rst_irq", {31'h0, irq}, 32'h0);
    do_load(IOB + 32'h08, T_W, rd); chk_val("rst_count", rd, 32'h0);
    do_load(IOB + 32'h0C, T_W, rd); chk_val("rst_cmp", rd, 32'hFFFF_FFFF);
    do_load(IOB + 32'h10, T_W, rd); chk_val("rst_ctrl", rd, 32'h0);

    // ---- RAM lanes ----
    do_store(32'h10, 32'h8081_F2F3, T_W);
    do_load(32'h10, T_B,  rd); chk_val("lb_10",  rd, 32'hFFFF_FFF3);
    do_load(32'h13, T_BU, rd); chk_val("lbu_13", rd, 32'h0000_0080);
    do_load(32'h12, T_H,  rd); chk_val("lh_12",  rd, 32'hFFFF_8081);
    do_load(32'h10, T_HU, rd); chk_val("lhu_10", rd, 32'h0000_F2F3);
    do_store(32'h11, 32'h0000_00AA, T_B);
    do_load(32'h10, T_W, rd); chk_val("lw_after_sb", rd, 32'h8081_AAF3);
    // Erroneous loads return 0 and never flag bus_err.
    do_load(32'h12, T_W, rd);  chk_val("lw_misalign", rd, 32'h0);
    do_load(32'h10, 3'd5, rd); chk_val("ld_illegal", rd, 32'h0);
    do_load(32'h200, T_W, rd); chk_val("lw_past_ram", rd, 32'h0);
    step();
    chk_val("load_no_err", {31'h0, bus_err}, 32'h0);

    // ---- store errors ----
    do_store(32'h20, 32'h1122_3344, T_W);
    do_store(32'h21, 32'h0000_BEEF, T_H);
    do_load(32'h20, T_W, rd); chk_val("sh_mis_dropped", rd, 32'h1122_3344);
    chk_val("sh_mis_err", {31'h0, bus_err}, 32'h1);
    do_load(32'h0000_4000, T_W, rd); chk_val("lw_unmapped", rd, 32'h0);
    pulse_reset();
    chk_val("err_cleared", {31'h0, bus_err}, 32'h0);

    // ---- switches and LED ----
    sw_in = 16'h5A5A;
    step();
    do_load(IOB + 32'h04, T_W, rd); chk_val("sw_1cyc", rd, 32'h0);
    step();
    do_load(IOB + 32'h04, T_W, rd); chk_val("sw_2cyc", rd, 32'h0000_5A5A);
    do_store(IOB, 32'hFFFF_1234, T_W);
    chk_val("led_out", {16'h0, led_out}, 32'h1234);
    do_load(IOB, T_W, rd); chk_val("led_read", rd, 32'h0000_1234);
    do_store(IOB, 32'h0000_0055, T_B);
    chk_val("led_sb_ignored", {16'h0, led_out}, 32'h1234);
    chk_val("led_sb_err", {31'h0, bus_err}, 32'h1);
    pulse_reset();
    do_store(IOB + 32'h04, 32'h0, T_W);
    chk_val("sw_store_err", {31'h0, bus_err}, 32'h1);
    pulse_reset();

    // ---- timer auto-reload ----
    do_store(IOB + 32'h0C, 32'd3, T_W);
    do_store(IOB + 32'h10, 32'h7, T_W);
    for (int i = 0; i < 5; i++) begin
      do_load(IOB + 32'h08, T_W, rd);
      chk_val($sformatf("count_%0d", i), rd, exp_cnt[i]);
      chk_val($sformatf("irq_%0d", i), {31'h0, irq}, (i == 4) ? 32'h1 : 32'h0);
      if (i < 4) step();
    end
    do_load(IOB + 32'h14, T_W, rd); chk_val("status_match", rd, 32'h1);
    do_store(IOB + 32'h14, 32'h1, T_W);     // COUNT 0 -> 1, no match
    chk_val("w1c_irq", {31'h0, irq}, 32'h0);

    // ---- W1C at the same edge as a new match ----
    step(); step();                          // COUNT 1 -> 2 -> 3
    do_load(IOB + 32'h08, T_W, rd); chk_val("count_pre_match", rd, 32'd3);
    do_store(IOB + 32'h14, 32'h1, T_W);
    do_load(IOB + 32'h14, T_W, rd); chk_val("set_wins", rd, 32'h1);
    chk_val("set_wins_irq", {31'h0, irq}, 32'h1);
    do_store(IOB + 32'h14, 32'h0, T_W);
    do_load(IOB + 32'h14, T_W, rd); chk_val("w0_no_effect", rd, 32'h1);

    // ---- CPU store to COUNT overrides the increment ----
    do_store(IOB + 32'h08, 32'h100, T_W);
    do_load(IOB + 32'h08, T_W, rd); chk_val("count_store", rd, 32'h100);
    step();
    do_load(IOB + 32'h08, T_W, rd); chk_val("count_inc", rd, 32'h101);

    // ---- reset mid-count ----
    do_store(IOB, 32'h0000_00C3, T_W);
    do_store(IOB + 32'h08, 32'd5, T_W);
    step(); step();                          // 5 -> 6 -> 7
    do_load(IOB + 32'h08, T_W, rd); chk_val("count_7", rd, 32'd7);
    pulse_reset();
    do_load(IOB + 32'h08, T_W, rd); chk_val("mid_rst_count", rd, 32'h0);
    do_load(IOB + 32'h10, T_W, rd); chk_val("mid_rst_ctrl", rd, 32'h0);
    do_load(IOB + 32'h0C, T_W, rd); chk_val("mid_rst_cmp", rd, 32'hFFFF_FFFF);
    chk_val("mid_rst_led", {16'h0, led_out}, 32'h0);
    do_load(IOB + 32'h14, T_W, rd); chk_val("mid_rst_status", rd, 32'h0);
    do_load(32'h10, T_W, rd); chk_val("ram_retained", rd, 32'h8081_AAF3);
    step();
    do_load(IOB + 32'h08, T_W, rd); chk_val("count_held", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_io_responder.md
Name: dm_io_responder

Overview:
- Data-side responder for the single-cycle CPU's load/store bus.
- Decodes each CPU access into a word-addressed RAM region or a memory-mapped I/O region: LED register, switch input, and a compare-match timer with interrupt.
- Handles byte/half/word lanes per DMType. Loads are combinational, so the CPU completes them in the same cycle. Stores and all timer state update on the clock edge.

Parameters:
- RAM_WORDS, 128, RAM depth in 32-bit words; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- IO_BASE, 32'h0000_FF00, base of the 256-byte I/O window (matched on addr[31:8]).

Ports:
- clk  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- DMWr  in  1  store strobe; a store is performed at the clk edge when high.
- addr  in  32  byte address from the CPU.
- din  in  32  store data; the value to store is in the low bits.
- DMType  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
- dout  out  32  load data (combinational from addr, DMType and current state).
- sw_in  in  16  board switches; sampled through a 2-flop synchronizer.
- led_out  out  16  LED register.
- irq  out  1  timer interrupt = STATUS.match & CTRL.irq_en.
- bus_err  out  1  sticky access-error flag.

Behaviour:
- Reset, at a clk edge with reset=1:
  - LED, COUNT, CTRL and STATUS clear to 0; CMP sets to 32'hFFFF_FFFF.
  - bus_err clears to 0; synchronizer flops clear to 0.
  - RAM contents are not cleared.
  - Reset has priority over any store or timer event in the same cycle.
- Alignment:
  - Word access requires addr[1:0]=00; half access requires addr[0]=0.
- Error conditions, all treated identically:
  - misaligned access;
  - illegal DMType;
  - address outside both RAM and the I/O window;
  - unmapped I/O offset;
  - non-word access to the I/O window.
- Effect of an error:
  - the load returns 32'h0;
  - a store is dropped;
  - bus_err sets at the next edge.
  - bus_err is set by an erroneous access only when DMWr=1.
  - Misaligned and illegal loads are not flagged, because the single-cycle CPU presents addr every cycle.
- RAM loads:
  - Lane is selected by addr[1:0] for bytes and addr[1] for halves, little-endian.
  - Signed types sign-extend; unsigned types zero-extend.
- RAM stores:
  - Only the addressed byte/half lanes are written, taking din[7:0] or din[15:0].
  - Other lanes are preserved.
- I/O map, as offsets from IO_BASE; word accesses only:
  - 0x00 LED: R/W, bits [15:0]; reads return zero in bits [31:16].
  - 0x04 SW: read-only, the synchronized sw_in (2-cycle latency); a store here is an error.
  - 0x08 COUNT: R/W.
  - 0x0C CMP: R/W.
  - 0x10 CTRL: R/W, bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x14 STATUS: bit0 match; write 1 to clear; writing 0 has no effect.
- Timer, evaluated every edge when CTRL.en=1:
  - if COUNT==CMP: STATUS.match <= 1, and COUNT <= 0 if auto_reload, else COUNT+1;
  - otherwise COUNT <= COUNT+1.
  - COUNT wraps from FFFF_FFFF to 0 with no flag unless CMP matches.
- Simultaneous events at one edge:
  - a CPU store to COUNT overrides the increment and reload;
  - match detection uses the pre-edge COUNT and CMP, so a store to CMP takes effect next cycle;
  - a STATUS W1C in the same cycle as a new match leaves match=1 (set wins).
- Timer disabled (en=0): COUNT holds and no match is generated.
- irq is combinational from registered STATUS and CTRL, so it rises the cycle after the match edge.

Test Plan:
- RAM lanes: sw 0x8081_F2F3 @0x10.
  - lb 0x10 -> FFFF_FFF3; lbu 0x13 -> 0000_0080.
  - lh 0x12 -> FFFF_8081; lhu 0x10 -> 0000_F2F3.
  - then sb 0x11=0xAA; lw 0x10 -> 8081_AAF3.
- Errors:
  - sh to 0x21 leaves RAM unchanged and sets bus_err=1.
  - lw from 0x0000_4000 returns 0.
  - a subsequent reset clears bus_err.
- Timer auto-reload:
  - CMP=3, CTRL=0b111.
  - COUNT sequence 0,1,2,3,0; STATUS.match=1 and irq=1 on the cycle after COUNT=3.
  - W1C to STATUS drops irq.
- Simultaneous events:
  - W1C on STATUS at the same edge as a match -> match stays 1.
  - Store COUNT=0x100 while enabled -> next read 0x100, not an incremented value.
- I/O: sw_in=0x5A5A.
  - lw IO_BASE+4 -> 0x5A5A after 2 cycles.
  - sw LED=0xFFFF_1234 -> led_out=0x1234.
  - sb to the LED address -> ignored, bus_err=1.
- Reset mid-count: assert reset while COUNT=7 and en=1.
  - Next cycle COUNT=0, CTRL=0, CMP=FFFF_FFFF, led_out=0.
  - RAM word 0x10 is retained.
